vc_dest_arbiter: RTL and testbench

- Weighted round-robin scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) in the transmitter.
- Each cycle it issues at most one pop to one VC and never pops both VCs in the same cycle.
- Each popped word is routed to D0 or D1 by its destination bit, so no destination receives two pushes in one cycle.
- Honours destination back-pressure (pause) and the FSM active enable.

---
 rtl/vc_arb_pkg.sv | 13 +
 rtl/vc_arb_credit.sv | 24 ++
 rtl/vc_dest_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vc_dest_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared constants for the VC-to-destination arbiter.
// State encoding, default datapath geometry and credit counter width.
package vc_arb_pkg;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SERVE_VC0 = 2'd1;
   localparam logic [1:0] SERVE_VC1 = 2'd2;

   localparam int DATA_W   = 6;
   localparam int DEST_BIT = 4;
   localparam int CRED_W   = 4;

endpackage

// File: rtl/vc_arb_credit.sv
// vc_arb_credit: consecutive-grant counter for the VC currently being served.
// 'last' flags that a pop taken now consumes the final credit of the weight.
module vc_arb_credit
   import vc_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   input  logic [CRED_W-1:0] weight,
   output logic              last
);

   logic [CRED_W-1:0] credit;

   assign last = ({1'b0, credit} + (CRED_W+1)'(1)) >= {1'b0, weight};

   // Credit clears on reset or VC switch, advances once per pop.
   always_ff @(posedge clk) begin
      if (rst || clr) credit <= '0;
      else if (inc)   credit <= credit + CRED_W'(1);
   end

endmodule

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: weighted round-robin pop scheduler between VC0/VC1 FIFOs,
// routing each returned word to D0/D1 by its destination bit.
// Optional build macro VC_ARB_STATS_EN adds CNT_D0/CNT_D1/CNT_DROP counters.
module vc_dest_arbiter #(
   parameter int DATA_W     = vc_arb_pkg::DATA_W,
   parameter int DEST_BIT   = vc_arb_pkg::DEST_BIT,
   parameter int VC0_WEIGHT = 2,
   parameter int VC1_WEIGHT = 1
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic              VC0_EMPTY,
   input  logic              VC1_EMPTY,
   input  logic              VC0_AL_EMPTY,
   input  logic              VC1_AL_EMPTY,
   input  logic              VC0_VALID,
   input  logic              VC1_VALID,
   input  logic [DATA_W-1:0] DATA_OUT_VC0,
   input  logic [DATA_W-1:0] DATA_OUT_VC1,
   input  logic              D0_PAUSE,
   input  logic              D1_PAUSE,
   input  logic              D0_FULL,
   input  logic              D1_FULL,
   output logic              POP_VC0,
   output logic              POP_VC1,
   output logic              PUSH_D0,
   output logic              PUSH_D1,
   output logic [DATA_W-1:0] DATA_TO_D0,
   output logic [DATA_W-1:0] DATA_TO_D1,
   output logic              ARB_IDLE,
   output logic              DROP_ERR
`ifdef VC_ARB_STATS_EN
   ,
   output logic [7:0]        CNT_D0,
   output logic [7:0]        CNT_D1,
   output logic [7:0]        CNT_DROP
`endif
);
   import vc_arb_pkg::*;

   logic [1:0]        state, state_nxt;
   logic              last_vc;          // 1 when VC1 was granted most recently
   logic              pop_ok, elig0, elig1, cur_elig, oth_elig, serve1;
   logic [1:0]        oth_state;
   logic              pop0_nxt, pop1_nxt, cred_clr, cred_inc, cred_last;
   logic [CRED_W-1:0] weight;
   logic [1:0]        vld_pipe;         // [0] pop issued, [1] read data due
   logic              any_vld, dest, dst_full, acc_d0, acc_d1, drop;
   logic [DATA_W-1:0] word;

   // Destination is unknown until the word returns, so either pause blocks.
   assign pop_ok   = ENABLE & ~D0_PAUSE & ~D1_PAUSE;
   // EMPTY lags a pop by a cycle; don't re-pop a FIFO whose last entry is leaving.
   assign elig0    = ~VC0_EMPTY & ~(POP_VC0 & VC0_AL_EMPTY);
   assign elig1    = ~VC1_EMPTY & ~(POP_VC1 & VC1_AL_EMPTY);
   assign serve1   = (state == SERVE_VC1);
   assign cur_elig = serve1 ? elig1 : elig0;
   assign oth_elig = serve1 ? elig0 : elig1;
   assign oth_state = serve1 ? SERVE_VC0 : SERVE_VC1;
   assign weight   = serve1 ? CRED_W'(VC1_WEIGHT) : CRED_W'(VC0_WEIGHT);

   vc_arb_credit u_credit (
      .clk    (clk),
      .rst    (RESET),
      .clr    (cred_clr),
      .inc    (cred_inc),
      .weight (weight),
      .last   (cred_last)
   );

   // Next-state, pop decision and credit control.
   always_comb begin
      state_nxt = state;
      pop0_nxt  = 1'b0;
      pop1_nxt  = 1'b0;
      cred_clr  = 1'b0;
      cred_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (ENABLE) begin
               if (elig0 && (!elig1 || last_vc)) state_nxt = SERVE_VC0;
               else if (elig1)                   state_nxt = SERVE_VC1;
            end
         end
         SERVE_VC0, SERVE_VC1: begin
            if (!ENABLE || (!cur_elig && !oth_elig)) begin
               state_nxt = IDLE;
               cred_clr  = 1'b1;
            end else if (!cur_elig) begin
               state_nxt = oth_state;
               cred_clr  = 1'b1;
            end else if (pop_ok) begin
               pop0_nxt = ~serve1;
               pop1_nxt = serve1;
               if (cred_last) begin
                  state_nxt = oth_state;
                  cred_clr  = 1'b1;
               end else begin
                  cred_inc = 1'b1;
               end
            end
            // no pop_ok: hold state and credit
         end
         default: begin
            state_nxt = IDLE;
            cred_clr  = 1'b1;
         end
      endcase
   end

   // Scheduler state, pop strobes and in-flight tracking.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state    <= IDLE;
         last_vc  <= 1'b1;
         POP_VC0  <= 1'b0;
         POP_VC1  <= 1'b0;
         vld_pipe <= '0;
      end else begin
         state    <= state_nxt;
         POP_VC0  <= pop0_nxt;
         POP_VC1  <= pop1_nxt;
         vld_pipe <= {vld_pipe[0], pop0_nxt | pop1_nxt};
         if (pop0_nxt || pop1_nxt) last_vc <= pop1_nxt;
      end
   end

   // Read data is only honoured when a pop is actually outstanding, so words
   // popped just before a reset are discarded.
   assign any_vld  = (VC0_VALID | VC1_VALID) & vld_pipe[1];
   assign word     = VC0_VALID ? DATA_OUT_VC0 : DATA_OUT_VC1;
   assign dest     = word[DEST_BIT];
   assign dst_full = dest ? D1_FULL : D0_FULL;
   assign acc_d0   = any_vld & ~dest & ~D0_FULL;
   assign acc_d1   = any_vld & dest & ~D1_FULL;
   assign drop     = any_vld & (dst_full | (VC0_VALID & VC1_VALID));

   assign ARB_IDLE = (state == IDLE) & ~POP_VC0 & ~POP_VC1 & ~vld_pipe[1];

   // Push stage: route returned word, zero the idle destination, latch drops.
   always_ff @(posedge clk) begin
      if (RESET) begin
         PUSH_D0    <= 1'b0;
         PUSH_D1    <= 1'b0;
         DATA_TO_D0 <= '0;
         DATA_TO_D1 <= '0;
         DROP_ERR   <= 1'b0;
      end else begin
         PUSH_D0    <= acc_d0;
         PUSH_D1    <= acc_d1;
         DATA_TO_D0 <= acc_d0 ? word : '0;
         DATA_TO_D1 <= acc_d1 ? word : '0;
         DROP_ERR   <= DROP_ERR | drop;
      end
   end

`ifdef VC_ARB_STATS_EN
   // Push counters wrap; drop counter saturates.
   always_ff @(posedge clk) begin
      if (RESET) begin
         CNT_D0   <= '0;
         CNT_D1   <= '0;
         CNT_DROP <= '0;
      end else begin
         if (acc_d0) CNT_D0 <= CNT_D0 + 8'd1;
         if (acc_d1) CNT_D1 <= CNT_D1 + 8'd1;
         if (drop && CNT_DROP != 8'hFF) CNT_DROP <= CNT_DROP + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// tb_vc_dest_arbiter: directed tests with a queue model of the VC FIFOs.
module tb_vc_dest_arbiter;
   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          RESET, ENABLE;
   logic          VC0_EMPTY, VC1_EMPTY, VC0_AL_EMPTY, VC1_AL_EMPTY;
   logic          VC0_VALID, VC1_VALID;
   logic [DW-1:0] DATA_OUT_VC0, DATA_OUT_VC1;
   logic          D0_PAUSE, D1_PAUSE, D0_FULL, D1_FULL;
   logic          POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, ARB_IDLE, DROP_ERR;
   logic [DW-1:0] DATA_TO_D0, DATA_TO_D1;
`ifdef VC_ARB_STATS_EN
   logic [7:0]    CNT_D0, CNT_D1, CNT_DROP;
`endif

   always #5 clk = ~clk;

   vc_dest_arbiter dut (
      .clk(clk), .RESET(RESET), .ENABLE(ENABLE),
      .VC0_EMPTY(VC0_EMPTY), .VC1_EMPTY(VC1_EMPTY),
      .VC0_AL_EMPTY(VC0_AL_EMPTY), .VC1_AL_EMPTY(VC1_AL_EMPTY),
      .VC0_VALID(VC0_VALID), .VC1_VALID(VC1_VALID),
      .DATA_OUT_VC0(DATA_OUT_VC0), .DATA_OUT_VC1(DATA_OUT_VC1),
      .D0_PAUSE(D0_PAUSE), .D1_PAUSE(D1_PAUSE),
      .D0_FULL(D0_FULL), .D1_FULL(D1_FULL),
      .POP_VC0(POP_VC0), .POP_VC1(POP_VC1),
      .PUSH_D0(PUSH_D0), .PUSH_D1(PUSH_D1),
      .DATA_TO_D0(DATA_TO_D0), .DATA_TO_D1(DATA_TO_D1),
      .ARB_IDLE(ARB_IDLE), .DROP_ERR(DROP_ERR)
`ifdef VC_ARB_STATS_EN
      , .CNT_D0(CNT_D0), .CNT_D1(CNT_D1), .CNT_DROP(CNT_DROP)
`endif
   );

   int checks = 0, failures = 0, cyc = 0;
   int both_pops = 0, bad_data = 0;
   logic [DW-1:0] q0[$], q1[$];
   int            pop_cyc[$];
   bit            pop_vc[$];
   int            push_cyc[$];
   bit            push_dst[$];
   logic [DW-1:0] push_dat[$];

   task automatic flags();
      VC0_EMPTY    = (q0.size() == 0);
      VC1_EMPTY    = (q1.size() == 0);
      VC0_AL_EMPTY = (q0.size() <= 1);
      VC1_AL_EMPTY = (q1.size() <= 1);
   endtask

   // One clock: FIFO model answers last cycle's pops, then outputs are logged.
   task automatic step();
      logic p0, p1;
      p0 = (POP_VC0 === 1'b1);
      p1 = (POP_VC1 === 1'b1);
      @(posedge clk); #1;
      cyc++;
      VC0_VALID = p0;
      VC1_VALID = p1;
      DATA_OUT_VC0 = '0;
      DATA_OUT_VC1 = '0;
      if (p0 && q0.size() > 0) DATA_OUT_VC0 = q0.pop_front();
      if (p1 && q1.size() > 0) DATA_OUT_VC1 = q1.pop_front();
      flags();
      if (POP_VC0 === 1'b1 && POP_VC1 === 1'b1) both_pops++;
      if (POP_VC0 === 1'b1) begin pop_cyc.push_back(cyc); pop_vc.push_back(1'b0); end
      if (POP_VC1 === 1'b1) begin pop_cyc.push_back(cyc); pop_vc.push_back(1'b1); end
      if (PUSH_D0 === 1'b1) begin push_cyc.push_back(cyc); push_dst.push_back(1'b0); push_dat.push_back(DATA_TO_D0); end
      if (PUSH_D1 === 1'b1) begin push_cyc.push_back(cyc); push_dst.push_back(1'b1); push_dat.push_back(DATA_TO_D1); end
      if (PUSH_D0 !== 1'b1 && DATA_TO_D0 !== '0) bad_data++;
      if (PUSH_D1 !== 1'b1 && DATA_TO_D1 !== '0) bad_data++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      RESET = 1'b1; ENABLE = 1'b0;
      D0_PAUSE = 1'b0; D1_PAUSE = 1'b0; D0_FULL = 1'b0; D1_FULL = 1'b0;
      q0.delete(); q1.delete(); flags();
      run(2);
      RESET = 1'b0;
      pop_cyc.delete(); pop_vc.delete();
      push_cyc.delete(); push_dst.delete(); push_dat.delete();
      both_pops = 0; bad_data = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({POP_VC0, POP_VC1} !== 2'b00) begin failures++; $display("FAIL rst_pop got=%b exp=00", {POP_VC0, POP_VC1}); end
      checks++; if ({PUSH_D0, PUSH_D1} !== 2'b00) begin failures++; $display("FAIL rst_push got=%b exp=00", {PUSH_D0, PUSH_D1}); end
      checks++; if ({DATA_TO_D0, DATA_TO_D1} !== '0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0", DATA_TO_D0, DATA_TO_D1); end
      checks++; if (ARB_IDLE !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", ARB_IDLE); end
      checks++; if (DROP_ERR !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b exp=0", DROP_ERR); end
   endtask

   task automatic test_single_vc();
      logic [DW-1:0] w[4];
      bit            ed[4];
      w  = '{6'h01, 6'h12, 6'h03, 6'h14};
      ed = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) q0.push_back(w[i]);
      flags(); ENABLE = 1'b1;
      run(20);
      checks++; if (pop_cyc.size() != 4) begin failures++; $display("FAIL t1_pops got=%0d exp=4", pop_cyc.size()); end
      checks++; if (push_cyc.size() != 4) begin failures++; $display("FAIL t1_pushes got=%0d exp=4", push_cyc.size()); end
      for (int i = 0; i < 4 && i < push_cyc.size() && i < pop_cyc.size(); i++) begin
         checks++; if (pop_vc[i] !== 1'b0) begin failures++; $display("FAIL t1_pop_vc[%0d] got=%0d exp=0", i, pop_vc[i]); end
         checks++; if (push_dst[i] !== ed[i]) begin failures++; $display("FAIL t1_dst[%0d] got=%0d exp=%0d", i, push_dst[i], ed[i]); end
         checks++; if (push_dat[i] !== w[i]) begin failures++; $display("FAIL t1_dat[%0d] got=%h exp=%h", i, push_dat[i], w[i]); end
         checks++; if (push_cyc[i] != pop_cyc[i] + 2) begin failures++; $display("FAIL t1_lat[%0d] got=%0d exp=%0d", i, push_cyc[i] - pop_cyc[i], 2); end
      end
      checks++; if (ARB_IDLE !== 1'b1) begin failures++; $display("FAIL t1_idle got=%b exp=1", ARB_IDLE); end
      checks++; if (bad_data != 0) begin failures++; $display("FAIL t1_idle_data got=%0d exp=0", bad_data); end
`ifdef VC_ARB_STATS_EN
      checks++; if ({CNT_D0, CNT_D1} !== {8'd2, 8'd2}) begin failures++; $display("FAIL t1_cnt got=%0d/%0d exp=2/2", CNT_D0, CNT_D1); end
`endif
   endtask

   task automatic test_weighted();
      bit            ev[12];
      logic [DW-1:0] ew[12];
      ev = '{0,0,1,0,0,1,0,0,1,1,1,1};
      ew = '{6'h00,6'h01,6'h30,6'h02,6'h03,6'h31,6'h04,6'h05,6'h32,6'h33,6'h34,6'h35};
      do_reset();
      for (int i = 0; i < 6; i++) begin q0.push_back(DW'(i)); q1.push_back(DW'(6'h30 + i)); end
      flags(); ENABLE = 1'b1;
      run(60);
      checks++; if (pop_cyc.size() != 12) begin failures++; $display("FAIL t2_pops got=%0d exp=12", pop_cyc.size()); end
      checks++; if (both_pops != 0) begin failures++; $display("FAIL t2_dual_pop got=%0d exp=0", both_pops); end
      for (int i = 0; i < 12 && i < pop_vc.size(); i++) begin
         checks++; if (pop_vc[i] !== ev[i]) begin failures++; $display("FAIL t2_order[%0d] got=VC%0d exp=VC%0d", i, pop_vc[i], ev[i]); end
      end
      for (int i = 0; i < 12 && i < push_dat.size(); i++) begin
         checks++; if ({push_dst[i], push_dat[i]} !== {ew[i][4], ew[i]}) begin failures++; $display("FAIL t2_push[%0d] got=D%0d:%h exp=D%0d:%h", i, push_dst[i], push_dat[i], ew[i][4], ew[i]); end
      end
   endtask

   task automatic test_last_entry();
      do_reset();
      q0.push_back(6'h2A); flags(); ENABLE = 1'b1;
      run(10);
      checks++; if (pop_cyc.size() != 1) begin failures++; $display("FAIL t3_pops got=%0d exp=1", pop_cyc.size()); end
      checks++; if (push_cyc.size() != 1) begin failures++; $display("FAIL t3_pushes got=%0d exp=1", push_cyc.size()); end
      if (push_cyc.size() == 1) begin
         checks++; if ({push_dst[0], push_dat[0]} !== {1'b0, 6'h2A}) begin failures++; $display("FAIL t3_push got=D%0d:%h exp=D0:2a", push_dst[0], push_dat[0]); end
      end
   endtask

   task automatic test_pause();
      int n, kk;
      bit ev[6];
      ev = '{0,0,1,0,0,1};
      do_reset();
      for (int i = 0; i < 6; i++) begin q0.push_back(DW'(i)); q1.push_back(DW'(6'h30 + i)); end
      flags(); ENABLE = 1'b1;
      n = 0;
      while (pop_cyc.size() < 4 && n < 50) begin step(); n++; end
      checks++; if (pop_cyc.size() != 4) begin failures++; $display("FAIL t4_prepause got=%0d exp=4", pop_cyc.size()); end
      D1_PAUSE = 1'b1;
      run(5);
      checks++; if (pop_cyc.size() != 4) begin failures++; $display("FAIL t4_paused_pops got=%0d exp=4", pop_cyc.size()); end
      D1_PAUSE = 1'b0;
      kk = cyc;
      step();
      checks++; if (pop_cyc.size() != 5) begin failures++; $display("FAIL t4_resume got=%0d exp=5", pop_cyc.size()); end
      else begin
         checks++; if (pop_cyc[4] != kk + 1) begin failures++; $display("FAIL t4_resume_cyc got=%0d exp=%0d", pop_cyc[4], kk + 1); end
      end
      run(60);
      for (int i = 0; i < 6 && i < pop_vc.size(); i++) begin
         checks++; if (pop_vc[i] !== ev[i]) begin failures++; $display("FAIL t4_order[%0d] got=VC%0d exp=VC%0d", i, pop_vc[i], ev[i]); end
      end
      checks++; if (pop_cyc.size() != 12) begin failures++; $display("FAIL t4_total got=%0d exp=12", pop_cyc.size()); end
   endtask

   task automatic test_full_drop();
      do_reset();
      D1_FULL = 1'b1;
      q0.push_back(6'h15); flags(); ENABLE = 1'b1;
      run(8);
      checks++; if (pop_cyc.size() != 1) begin failures++; $display("FAIL t5_pops got=%0d exp=1", pop_cyc.size()); end
      checks++; if (push_cyc.size() != 0) begin failures++; $display("FAIL t5_pushes got=%0d exp=0", push_cyc.size()); end
      checks++; if (DROP_ERR !== 1'b1) begin failures++; $display("FAIL t5_drop got=%b exp=1", DROP_ERR); end
      D1_FULL = 1'b0;
      run(3);
      checks++; if (DROP_ERR !== 1'b1) begin failures++; $display("FAIL t5_sticky got=%b exp=1", DROP_ERR); end
`ifdef VC_ARB_STATS_EN
      checks++; if (CNT_DROP !== 8'd1) begin failures++; $display("FAIL t5_cnt_drop got=%0d exp=1", CNT_DROP); end
`endif
      do_reset();
      checks++; if (DROP_ERR !== 1'b0) begin failures++; $display("FAIL t5_clear got=%b exp=0", DROP_ERR); end
   endtask

   task automatic test_enable_gate();
      do_reset();
      q0.push_back(6'h05); q0.push_back(6'h06); flags();
      run(6);
      checks++; if (pop_cyc.size() != 0) begin failures++; $display("FAIL t7_disabled_pops got=%0d exp=0", pop_cyc.size()); end
      checks++; if (ARB_IDLE !== 1'b1) begin failures++; $display("FAIL t7_idle got=%b exp=1", ARB_IDLE); end
      ENABLE = 1'b1;
      run(12);
      checks++; if (push_cyc.size() != 2) begin failures++; $display("FAIL t7_pushes got=%0d exp=2", push_cyc.size()); end
   endtask

   task automatic test_reset_midflight();
      int n;
      do_reset();
      q1.push_back(6'h1C); flags(); ENABLE = 1'b1;
      n = 0;
      while (POP_VC1 !== 1'b1 && n < 20) begin step(); n++; end
      checks++; if (POP_VC1 !== 1'b1) begin failures++; $display("FAIL t6_pop got=%b exp=1", POP_VC1); end
      step();
      RESET = 1'b1;
      step();
      checks++; if ({POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, DROP_ERR} !== 5'b0) begin failures++; $display("FAIL t6_outs got=%b exp=00000", {POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, DROP_ERR}); end
      checks++; if ({DATA_TO_D0, DATA_TO_D1} !== '0) begin failures++; $display("FAIL t6_data got=%h/%h exp=0", DATA_TO_D0, DATA_TO_D1); end
      checks++; if (ARB_IDLE !== 1'b1) begin failures++; $display("FAIL t6_idle got=%b exp=1", ARB_IDLE); end
      RESET = 1'b0;
      run(5);
      checks++; if (push_cyc.size() != 0) begin failures++; $display("FAIL t6_pushes got=%0d exp=0", push_cyc.size()); end
      checks++; if (ARB_IDLE !== 1'b1) begin failures++; $display("FAIL t6_idle_after got=%b exp=1", ARB_IDLE); end
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b0;
      VC0_VALID = 1'b0; VC1_VALID = 1'b0;
      DATA_OUT_VC0 = '0; DATA_OUT_VC1 = '0;
      D0_PAUSE = 1'b0; D1_PAUSE = 1'b0; D0_FULL = 1'b0; D1_FULL = 1'b0;
      flags();
      test_reset();
      test_single_vc();
      test_weighted();
      test_last_entry();
      test_pause();
      test_full_drop();
      test_enable_gate();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
